// File: rtl/ddcg_reg_bank.sv
// ddcg_reg_bank: grouped register bank with data-driven clock gating.
// A group is clocked only when the write enable is high and its incoming
// data differs from its stored value. A small measurement FSM counts
// clocked and gated group-cycles over a programmable window, so the
// switching activity of a datapath register can be characterised.
module ddcg_reg_bank #(
  parameter int               WIDTH     = 16,
  parameter int               GROUP     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 16,
  parameter int               ICG_STYLE = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [WIDTH-1:0]         d,
  output logic [WIDTH-1:0]         q,
  output logic [WIDTH/GROUP-1:0]   grp_ce,
  input  logic                     meas_start,
  input  logic [CNT_W-1:0]         win_len,
  output logic                     meas_busy,
  output logic                     meas_done,
  output logic [CNT_W-1:0]         clocked_cnt,
  output logic [CNT_W-1:0]         gated_cnt
);

  localparam int NG = WIDTH / GROUP;
  localparam int PW = $clog2(NG + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  logic [NG-1:0]    w_grpCe;
  logic [WIDTH-1:0] w_q;
  logic [PW-1:0]    w_pop;
  logic [CNT_W:0]   w_clkSum;
  logic [CNT_W:0]   w_gatSum;
  logic [CNT_W-1:0] w_winLoad;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_remaining;
  logic [CNT_W-1:0] r_clocked;
  logic [CNT_W-1:0] r_gated;

  // A group needs a clock only when a write would actually change it.
  always_comb begin
    w_grpCe = '0;
    for (int g = 0; g < NG; g++) begin
      w_grpCe[g] = en & (d[g*GROUP +: GROUP] != w_q[g*GROUP +: GROUP]);
    end
  end

  assign grp_ce = w_grpCe;
  assign q      = w_q;

  // One storage slice per gating group, built either around a glitch-free
  // latch-based clock gate or around a plain hold mux for FPGA targets.
  generate
    for (genvar g = 0; g < NG; g++) begin : gGroup
      logic [GROUP-1:0] r_grpQ;
      assign w_q[g*GROUP +: GROUP] = r_grpQ;

      if (ICG_STYLE == 1) begin : gIcg
        logic r_lat;
        logic w_gclk;

        // Enable is captured while clk is low and frozen while it is high,
        // so the gated clock can never produce a runt pulse.
        always_latch begin
          if (!rst_n) begin
            r_lat <= 1'b0;
          end else if (!clk) begin
            r_lat <= w_grpCe[g];
          end
        end

        assign w_gclk = clk & r_lat;

        // Group flops run on the gated clock; reset does not depend on it.
        always_ff @(posedge w_gclk or negedge rst_n) begin
          if (!rst_n) begin
            r_grpQ <= RESET_VAL[g*GROUP +: GROUP];
          end else begin
            r_grpQ <= d[g*GROUP +: GROUP];
          end
        end
      end else begin : gMux
        // Free-running clock with a hold mux gives the same function.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_grpQ <= RESET_VAL[g*GROUP +: GROUP];
          end else if (w_grpCe[g]) begin
            r_grpQ <= d[g*GROUP +: GROUP];
          end
        end
      end
    end
  endgenerate

  // Number of groups clocked in the current cycle.
  always_comb begin
    w_pop = '0;
    for (int g = 0; g < NG; g++) begin
      w_pop = w_pop + PW'(w_grpCe[g]);
    end
  end

  // Sums carry one extra bit so overflow can be detected and clamped.
  assign w_clkSum  = {1'b0, r_clocked} + (CNT_W+1)'(w_pop);
  assign w_gatSum  = {1'b0, r_gated} + (CNT_W+1)'(PW'(NG) - w_pop);
  assign w_winLoad = (win_len == '0) ? CNT_W'(1) : win_len;

  // Measurement state register on the ungated clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: start is only honoured from IDLE, and the window
  // closes on the cycle whose remaining count is one.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (meas_start) w_next = MEASURE;
      MEASURE: if (r_remaining == CNT_W'(1)) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Window countdown and saturating activity counters; the counters keep
  // their last values after DONE until the next window is started.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_remaining <= '0;
      r_clocked   <= '0;
      r_gated     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (meas_start) begin
            r_remaining <= w_winLoad;
            r_clocked   <= '0;
            r_gated     <= '0;
          end
        end
        MEASURE: begin
          r_clocked   <= w_clkSum[CNT_W] ? '1 : w_clkSum[CNT_W-1:0];
          r_gated     <= w_gatSum[CNT_W] ? '1 : w_gatSum[CNT_W-1:0];
          r_remaining <= r_remaining - CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign meas_busy   = (r_state == MEASURE);
  assign meas_done   = (r_state == DONE);
  assign clocked_cnt = r_clocked;
  assign gated_cnt   = r_gated;

endmodule

// File: tb/tb_ddcg_reg_bank.sv
// tb_ddcg_reg_bank: drives two bank instances (latch-gated with 16-bit
// counters, mux-style with 4-bit counters) from the same stimulus and
// compares both against a cycle-level reference model.
module tb_ddcg_reg_bank;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] d;
  logic        start;
  logic [15:0] win;

  logic [15:0] q,      qS;
  logic [3:0]  ce,     ceS;
  logic        busy,   busyS;
  logic        done,   doneS;
  logic [15:0] clkCnt, gatCnt;
  logic [3:0]  clkCntS, gatCntS;

  int nTests = 0;
  int nFail  = 0;

  logic [15:0] mQ;
  int          mState;
  int          mRem;
  int          mClk;
  int          mGat;
  logic [3:0]  lastCe;

  ddcg_reg_bank #(.WIDTH(16), .GROUP(4), .RESET_VAL(16'h0000), .CNT_W(16), .ICG_STYLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .d(d), .q(q), .grp_ce(ce),
    .meas_start(start), .win_len(win), .meas_busy(busy), .meas_done(done),
    .clocked_cnt(clkCnt), .gated_cnt(gatCnt)
  );

  ddcg_reg_bank #(.WIDTH(16), .GROUP(4), .RESET_VAL(16'h0000), .CNT_W(4), .ICG_STYLE(0)) dutS (
    .clk(clk), .rst_n(rst_n), .en(en), .d(d), .q(qS), .grp_ce(ceS),
    .meas_start(start), .win_len(win[3:0]), .meas_busy(busyS), .meas_done(doneS),
    .clocked_cnt(clkCntS), .gated_cnt(gatCntS)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [3:0] expCe();
    logic [3:0] e;
    for (int g = 0; g < 4; g++) e[g] = en && (d[g*4 +: 4] != mQ[g*4 +: 4]);
    return e;
  endfunction

  function automatic int satTo(int v, int m);
    return (v > m) ? m : v;
  endfunction

  task automatic modelReset();
    mQ = 16'h0000;
    mState = 0;
    mRem = 0;
    mClk = 0;
    mGat = 0;
  endtask

  // One clock cycle: check grp_ce mid-low-phase, advance model, check outputs.
  task automatic tick();
    logic [3:0] e;
    int pc;
    @(negedge clk);
    #1;
    e = expCe();
    nTests++;
    if (ce !== e) begin nFail++; $display("[TB] FAIL grp_ce: got %b expected %b", ce, e); end
    nTests++;
    if (ceS !== e) begin nFail++; $display("[TB] FAIL grp_ce_mux: got %b expected %b", ceS, e); end
    lastCe = ce;
    @(posedge clk);
    if (rst_n) begin
      pc = $countones(e);
      case (mState)
        0: if (start) begin
             mRem = (win == 0) ? 1 : int'(win);
             mClk = 0;
             mGat = 0;
             mState = 1;
           end
        1: begin
             mClk += pc;
             mGat += 4 - pc;
             if (mRem == 1) mState = 2;
             else mRem--;
           end
        default: mState = 0;
      endcase
      if (en) mQ = d;
    end
    #1;
    nTests++;
    if (q !== mQ) begin nFail++; $display("[TB] FAIL q: got %h expected %h", q, mQ); end
    nTests++;
    if (qS !== mQ) begin nFail++; $display("[TB] FAIL q_mux: got %h expected %h", qS, mQ); end
    nTests++;
    if (busy !== (mState == 1) || busyS !== (mState == 1)) begin
      nFail++; $display("[TB] FAIL busy: got %b/%b expected %b", busy, busyS, mState == 1);
    end
    nTests++;
    if (done !== (mState == 2) || doneS !== (mState == 2)) begin
      nFail++; $display("[TB] FAIL done: got %b/%b expected %b", done, doneS, mState == 2);
    end
    nTests++;
    if (clkCnt !== 16'(satTo(mClk, 65535)) || gatCnt !== 16'(satTo(mGat, 65535))) begin
      nFail++; $display("[TB] FAIL counts: got %0d/%0d expected %0d/%0d", clkCnt, gatCnt, mClk, mGat);
    end
    nTests++;
    if (clkCntS !== 4'(satTo(mClk, 15)) || gatCntS !== 4'(satTo(mGat, 15))) begin
      nFail++; $display("[TB] FAIL counts_sat: got %0d/%0d expected %0d/%0d",
                        clkCntS, gatCntS, satTo(mClk, 15), satTo(mGat, 15));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; d = 16'h0; start = 1'b0; win = 16'h0;
    modelReset();
    #11;
    nTests++;
    if (q !== 16'h0 || qS !== 16'h0) begin nFail++; $display("[TB] FAIL reset_q: got %h/%h expected 0000", q, qS); end
    nTests++;
    if (busy !== 1'b0 || done !== 1'b0 || clkCnt !== 16'h0 || gatCnt !== 16'h0) begin
      nFail++; $display("[TB] FAIL reset_meas: got %b %b %0d %0d expected 0 0 0 0", busy, done, clkCnt, gatCnt);
    end
    en = 1'b1;
    #1;
    nTests++;
    if (ce !== 4'b0000) begin nFail++; $display("[TB] FAIL reset_ce: got %b expected 0000", ce); end
    en = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_write();
    en = 1'b1; d = 16'hA5A5;
    tick();
    nTests++;
    if (lastCe !== 4'b1111) begin nFail++; $display("[TB] FAIL write_ce: got %b expected 1111", lastCe); end
    nTests++;
    if (q !== 16'hA5A5) begin nFail++; $display("[TB] FAIL write_q: got %h expected a5a5", q); end
  endtask

  task automatic test_partial();
    en = 1'b1; d = 16'h1234;
    tick();
    d = 16'h1238;
    tick();
    nTests++;
    if (lastCe !== 4'b0001) begin nFail++; $display("[TB] FAIL partial_ce: got %b expected 0001", lastCe); end
    nTests++;
    if (q !== 16'h1238) begin nFail++; $display("[TB] FAIL partial_q: got %h expected 1238", q); end
    en = 1'b0;
  endtask

  task automatic test_hold();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      d = 16'($urandom);
      tick();
      nTests++;
      if (lastCe !== 4'b0000 || q !== 16'h1238) begin
        nFail++; $display("[TB] FAIL hold: got ce %b q %h expected 0000 1238", lastCe, q);
      end
    end
  endtask

  task automatic test_measure();
    int pulses = 0;
    en = 1'b0; start = 1'b1; win = 16'd8;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      en = 1'b1; d = mQ ^ 16'h000F;
      start = (i == 3); win = 16'd2;
      tick();
      if (done) pulses++;
    end
    start = 1'b0;
    nTests++;
    if (done !== 1'b1 || clkCnt !== 16'd8 || gatCnt !== 16'd24) begin
      nFail++; $display("[TB] FAIL measure_counts: got %b %0d %0d expected 1 8 24", done, clkCnt, gatCnt);
    end
    nTests++;
    if (clkCntS !== 4'd8 || gatCntS !== 4'd15) begin
      nFail++; $display("[TB] FAIL measure_sat: got %0d %0d expected 8 15", clkCntS, gatCntS);
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) pulses++;
    end
    nTests++;
    if (pulses != 1) begin nFail++; $display("[TB] FAIL measure_pulses: got %0d expected 1", pulses); end
    nTests++;
    if (clkCnt !== 16'd8) begin nFail++; $display("[TB] FAIL measure_hold: got %0d expected 8", clkCnt); end
  endtask

  task automatic test_win_zero();
    en = 1'b0; start = 1'b1; win = 16'd0;
    tick();
    start = 1'b0; en = 1'b1; d = ~mQ;
    tick();
    nTests++;
    if (done !== 1'b1 || (clkCnt + gatCnt) !== 16'd4) begin
      nFail++; $display("[TB] FAIL win_zero: got done %b sum %0d expected 1 4", done, clkCnt + gatCnt);
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    en = 1'b0; start = 1'b1; win = 16'd10;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      en = 1'b1; d = ~mQ;
      tick();
    end
    nTests++;
    if (clkCntS !== 4'd15 || gatCntS !== 4'd0 || clkCnt !== 16'd40) begin
      nFail++; $display("[TB] FAIL saturation: got %0d %0d %0d expected 15 0 40", clkCntS, gatCntS, clkCnt);
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_reset_abort();
    int pulses = 0;
    en = 1'b1; d = 16'hBEEF; start = 1'b1; win = 16'd10;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d = ~mQ;
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    nTests++;
    if (q !== 16'h0 || qS !== 16'h0 || clkCnt !== 16'h0 || gatCnt !== 16'h0 || clkCntS !== 4'h0) begin
      nFail++; $display("[TB] FAIL abort_clear: got q %h cnt %0d/%0d expected 0", q, clkCnt, gatCnt);
    end
    nTests++;
    if (busy !== 1'b0 || done !== 1'b0 || busyS !== 1'b0) begin
      nFail++; $display("[TB] FAIL abort_fsm: got busy %b done %b expected 0 0", busy, done);
    end
    en = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || doneS) pulses++;
    end
    nTests++;
    if (pulses != 0) begin nFail++; $display("[TB] FAIL abort_pulse: got %0d expected 0", pulses); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      en    = ($urandom_range(0, 3) != 0);
      d     = ($urandom_range(0, 3) == 0) ? mQ : 16'($urandom);
      if ($urandom_range(0, 1) == 1) d[3:0] = mQ[3:0];
      start = ($urandom_range(0, 7) == 0);
      win   = 16'($urandom_range(0, 12));
      tick();
    end
    start = 1'b0;
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_partial();
    test_hold();
    test_measure();
    test_win_zero();
    test_saturation();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
